snake_step_scheduler: RTL and testbench

//  Sequences snake motion during PLAY. Issues one step request per move period to the

---
 rtl/snake_step_scheduler_pkg.sv | 37 +++
 rtl/snake_step_scheduler_flash_seq.sv | 77 +++++++
 rtl/snake_step_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_snake_step_scheduler.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_step_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : snake_step_scheduler_pkg
//  Purpose  : Shared snake definitions: game status encodings, direction
//             codes, scheduler state encoding and the reverse-direction helper.
//  Revision : 1.0  initial release
// ============================================================================
package snake_step_scheduler_pkg;

  // One-hot game status codes driven by the game controller
  localparam logic [2:0] GS_START = 3'b001;
  localparam logic [2:0] GS_PLAY  = 3'b010;
  localparam logic [2:0] GS_END   = 3'b100;

  // Heading codes carried on Step_dir
  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  // Scheduler states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FLASH = 2'b10,
    ST_HOLD  = 2'b11
  } sched_state_e;

  // Up/down and left/right pairs differ only in the low bit
  function automatic dir_e opposite_dir(input dir_e d);
    return dir_e'({d[1], ~d[0]});
  endfunction

endpackage
`default_nettype wire

// File: rtl/snake_step_scheduler_flash_seq.sv
`default_nettype none
// ============================================================================
//  Module   : snake_flash_seq
//  Purpose  : End-of-game blink sequencer. Toggles the display enable every
//             FLASH_HALF enabled clocks and reports completion after
//             FLASH_TOGGLES toggles, leaving the display visible.
//  Revision : 1.0  initial release
// ============================================================================
module snake_flash_seq #(
  parameter int FLASH_HALF    = 25_000_000,
  parameter int FLASH_TOGGLES = 6
) (
  input  logic Clk_50mhz,
  input  logic Rst_n,
  input  logic Enable_i,
  input  logic Clear_i,
  output logic Flash_sig_o,
  output logic Flash_done_o
);

  localparam int HW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam int TW = $clog2(FLASH_TOGGLES + 1);
  localparam logic [HW-1:0] HALF_LAST   = HW'(FLASH_HALF - 1);
  localparam logic [TW-1:0] TOGGLE_LAST = TW'(FLASH_TOGGLES - 1);

  logic [HW-1:0] half_q, half_d;
  logic [TW-1:0] tog_q, tog_d;
  logic          sig_q, sig_d;
  logic          done_q, done_d;

  // Next-state: clear dominates; count half periods only until the sequence ends
  always_comb begin
    half_d = half_q;
    tog_d  = tog_q;
    sig_d  = sig_q;
    done_d = done_q;
    if (Clear_i) begin
      half_d = '0;
      tog_d  = '0;
      sig_d  = 1'b1;
      done_d = 1'b0;
    end else if (Enable_i && !done_q) begin
      if (half_q == HALF_LAST) begin
        half_d = '0;
        sig_d  = ~sig_q;
        tog_d  = tog_q + TW'(1);
        if (tog_q == TOGGLE_LAST) begin
          // Even toggle count, so the display ends up visible
          done_d = 1'b1;
          sig_d  = 1'b1;
        end
      end else begin
        half_d = half_q + HW'(1);
      end
    end
  end

  // Blink counters and outputs
  always_ff @(posedge Clk_50mhz or negedge Rst_n) begin
    if (!Rst_n) begin
      half_q <= '0;
      tog_q  <= '0;
      sig_q  <= 1'b1;
      done_q <= 1'b0;
    end else begin
      half_q <= half_d;
      tog_q  <= tog_d;
      sig_q  <= sig_d;
      done_q <= done_d;
    end
  end

  assign Flash_sig_o  = sig_q;
  assign Flash_done_o = done_q;

endmodule
`default_nettype wire

// File: rtl/snake_step_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : snake_step_scheduler
//  Purpose  : Paces snake motion during play: one req/ack step per move
//             period with direction and grow flag, reversal-blocking key
//             arbitration, speed-up per apple, and the end-of-game blink.
//  Revision : 1.0  initial release
// ============================================================================
module snake_step_scheduler
  import snake_step_scheduler_pkg::*;
#(
  parameter int STEP_BASE     = 12_500_000,
  parameter int STEP_MIN      = 2_500_000,
  parameter int STEP_DEC      = 500_000,
  parameter int FLASH_HALF    = 25_000_000,
  parameter int FLASH_TOGGLES = 6,
  parameter int GROW_MAX      = 7
) (
  input  logic       Clk_50mhz,
  input  logic       Rst_n,
  input  logic [2:0] Game_status,
  input  logic       Key_up,
  input  logic       Key_down,
  input  logic       Key_left,
  input  logic       Key_right,
  input  logic       Apple_eaten,
  input  logic       Step_ack,
  output logic       Step_req,
  output logic [1:0] Step_dir,
  output logic       Grow,
  output logic       Flash_sig,
  output logic       Flash_done
);

  localparam int PW = $clog2(STEP_BASE + 1);
  localparam int GW = $clog2(GROW_MAX + 1);
  localparam logic [PW-1:0] PERIOD_BASE = PW'(STEP_BASE);
  localparam logic [PW-1:0] PERIOD_MIN  = PW'(STEP_MIN);
  localparam logic [PW-1:0] PERIOD_DEC  = PW'(STEP_DEC);
  localparam logic [GW-1:0] GROW_SAT    = GW'(GROW_MAX);

  sched_state_e  state_q, state_d;
  logic [PW-1:0] timer_q, timer_d;
  logic [PW-1:0] period_q, period_d;
  logic [GW-1:0] grow_cnt_q, grow_cnt_d;
  dir_e          dir_cur_q, dir_cur_d;
  dir_e          dir_next_q, dir_next_d;
  dir_e          step_dir_q, step_dir_d;
  logic          step_req_q, step_req_d;
  logic          grow_q, grow_d;

  logic          key_valid;
  dir_e          key_win;
  logic          ack_take;
  logic          grow_dec;
  logic          entering_run;
  logic          flash_done;

  // State follows Game_status; a finished blink parks in HOLD while END persists
  always_comb begin
    state_d = ST_IDLE;
    case (Game_status)
      GS_PLAY: state_d = ST_RUN;
      GS_END: begin
        if (state_q == ST_HOLD || (state_q == ST_FLASH && flash_done))
          state_d = ST_HOLD;
        else
          state_d = ST_FLASH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge Clk_50mhz or negedge Rst_n) begin
    if (!Rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Fixed-priority key arbiter: up > down > left > right
  always_comb begin
    key_valid = Key_up | Key_down | Key_left | Key_right;
    if (Key_up)        key_win = DIR_UP;
    else if (Key_down) key_win = DIR_DOWN;
    else if (Key_left) key_win = DIR_LEFT;
    else               key_win = DIR_RIGHT;
  end

  // Step timer, handshake, heading, growth and speed next-state logic
  always_comb begin
    timer_d      = timer_q;
    period_d     = period_q;
    grow_cnt_d   = grow_cnt_q;
    dir_cur_d    = dir_cur_q;
    dir_next_d   = dir_next_q;
    step_dir_d   = step_dir_q;
    step_req_d   = step_req_q;
    grow_d       = grow_q;
    ack_take     = 1'b0;
    grow_dec     = 1'b0;
    entering_run = (state_d == ST_RUN) && (state_q != ST_RUN);

    if (state_q == ST_RUN) begin
      ack_take = step_req_q && Step_ack;
      grow_dec = ack_take && grow_q && (grow_cnt_q != '0);
      if (ack_take) begin
        step_req_d = 1'b0;
        grow_d     = 1'b0;
      end
      // The ack cycle already counts towards the next period; >= guards a
      // period that shrank below the running count
      if (!step_req_q || ack_take) begin
        if (timer_q >= period_q - PW'(1)) begin
          timer_d    = '0;
          step_req_d = 1'b1;
          step_dir_d = dir_next_q;
          dir_cur_d  = dir_next_q;
          grow_d     = (grow_cnt_q != '0);
        end else begin
          timer_d = timer_q + PW'(1);
        end
      end
      // Reversal is judged against the heading in force after this edge
      if (key_valid && (key_win != opposite_dir(dir_cur_d)))
        dir_next_d = key_win;
      if (Apple_eaten && !grow_dec) begin
        if (grow_cnt_q != GROW_SAT) grow_cnt_d = grow_cnt_q + GW'(1);
      end else if (grow_dec && !Apple_eaten) begin
        grow_cnt_d = grow_cnt_q - GW'(1);
      end
      if (Apple_eaten)
        period_d = (int'(period_q) >= STEP_MIN + STEP_DEC) ? (period_q - PERIOD_DEC)
                                                           : PERIOD_MIN;
    end

    if (state_d == ST_IDLE) period_d = PERIOD_BASE;
    // Outstanding request is withdrawn when play stops; a late ack is moot
    if (state_d != ST_RUN) begin
      step_req_d = 1'b0;
      grow_d     = 1'b0;
    end
    if (entering_run) begin
      timer_d    = '0;
      dir_cur_d  = DIR_RIGHT;
      dir_next_d = DIR_RIGHT;
      step_dir_d = DIR_RIGHT;
      grow_cnt_d = '0;
      step_req_d = 1'b0;
      grow_d     = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge Clk_50mhz or negedge Rst_n) begin
    if (!Rst_n) begin
      timer_q    <= '0;
      period_q   <= PERIOD_BASE;
      grow_cnt_q <= '0;
      dir_cur_q  <= DIR_RIGHT;
      dir_next_q <= DIR_RIGHT;
      step_dir_q <= DIR_RIGHT;
      step_req_q <= 1'b0;
      grow_q     <= 1'b0;
    end else begin
      timer_q    <= timer_d;
      period_q   <= period_d;
      grow_cnt_q <= grow_cnt_d;
      dir_cur_q  <= dir_cur_d;
      dir_next_q <= dir_next_d;
      step_dir_q <= step_dir_d;
      step_req_q <= step_req_d;
      grow_q     <= grow_d;
    end
  end

  snake_flash_seq #(
    .FLASH_HALF   (FLASH_HALF),
    .FLASH_TOGGLES(FLASH_TOGGLES)
  ) u_flash_seq (
    .Clk_50mhz   (Clk_50mhz),
    .Rst_n       (Rst_n),
    .Enable_i    (state_q == ST_FLASH),
    .Clear_i     (Game_status != GS_END),
    .Flash_sig_o (Flash_sig),
    .Flash_done_o(flash_done)
  );

  assign Step_req   = step_req_q;
  assign Step_dir   = step_dir_q;
  assign Grow       = grow_q;
  assign Flash_done = flash_done;

endmodule
`default_nettype wire

// File: tb/tb_snake_step_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_snake_step_scheduler
//  Purpose  : Self-checking bench for snake_step_scheduler with a cycle-level
//             behavioural model, directed scenarios and randomized play.
//  Revision : 1.0  initial release
// ============================================================================
module tb_snake_step_scheduler;

  localparam int SB = 20, SM = 8, SD = 4, FH = 10, FT = 6, GM = 7;
  localparam int FLASH_TOTAL = FH * FT;
  localparam int MD_IDLE = 0, MD_RUN = 1, MD_FLASH = 2, MD_HOLD = 3;

  logic       Clk_50mhz = 1'b0;
  logic       Rst_n = 1'b1;
  logic [2:0] Game_status = 3'b001;
  logic       Key_up = 1'b0, Key_down = 1'b0, Key_left = 1'b0, Key_right = 1'b0;
  logic       Apple_eaten = 1'b0, Step_ack = 1'b0;
  logic       Step_req, Grow, Flash_sig, Flash_done;
  logic [1:0] Step_dir;

  snake_step_scheduler #(
    .STEP_BASE(SB), .STEP_MIN(SM), .STEP_DEC(SD),
    .FLASH_HALF(FH), .FLASH_TOGGLES(FT), .GROW_MAX(GM)
  ) dut (
    .Clk_50mhz(Clk_50mhz), .Rst_n(Rst_n), .Game_status(Game_status),
    .Key_up(Key_up), .Key_down(Key_down), .Key_left(Key_left), .Key_right(Key_right),
    .Apple_eaten(Apple_eaten), .Step_ack(Step_ack),
    .Step_req(Step_req), .Step_dir(Step_dir), .Grow(Grow),
    .Flash_sig(Flash_sig), .Flash_done(Flash_done)
  );

  always #5 Clk_50mhz = ~Clk_50mhz;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Behavioural model: heading/queued direction, elapsed clocks, pending growth,
  // clocks spent blinking
  int m_mode, m_period, m_elapsed, m_heading, m_queued, m_pending, m_fc, m_dir;
  bit m_req, m_grow;
  int opp [4] = '{1, 0, 3, 2};

  task automatic model_reset();
    m_mode = MD_IDLE; m_period = SB; m_elapsed = 0;
    m_heading = 3; m_queued = 3; m_pending = 0; m_fc = 0;
    m_dir = 3; m_req = 1'b0; m_grow = 1'b0;
  endtask

  task automatic model_tick();
    int  nm;
    int  win;
    bit  was_req, ack_now, grew;
    case (Game_status)
      3'b010:  nm = MD_RUN;
      3'b100:  nm = (m_mode == MD_HOLD || (m_mode == MD_FLASH && m_fc >= FLASH_TOTAL))
                    ? MD_HOLD : MD_FLASH;
      default: nm = MD_IDLE;
    endcase
    if (Game_status != 3'b100) m_fc = 0;
    else if (m_mode == MD_FLASH && m_fc < FLASH_TOTAL) m_fc++;

    if (m_mode == MD_RUN) begin
      was_req = m_req;
      ack_now = m_req && Step_ack;
      grew    = ack_now && m_grow;
      if (ack_now) begin m_req = 1'b0; m_grow = 1'b0; end
      if (!was_req || ack_now) begin
        m_elapsed++;
        if (m_elapsed >= m_period) begin
          m_elapsed = 0; m_req = 1'b1;
          m_dir = m_queued; m_heading = m_queued;
          m_grow = (m_pending > 0);
        end
      end
      win = Key_up ? 0 : Key_down ? 1 : Key_left ? 2 : Key_right ? 3 : -1;
      if (win >= 0 && win != opp[m_heading]) m_queued = win;
      if (Apple_eaten && !grew) m_pending = (m_pending + 1 > GM) ? GM : m_pending + 1;
      else if (grew && !Apple_eaten) m_pending--;
      if (Apple_eaten) m_period = (m_period - SD < SM) ? SM : m_period - SD;
    end
    if (nm == MD_IDLE) m_period = SB;
    if (nm != MD_RUN) begin m_req = 1'b0; m_grow = 1'b0; end
    if (nm == MD_RUN && m_mode != MD_RUN) begin
      m_elapsed = 0; m_heading = 3; m_queued = 3; m_pending = 0;
      m_dir = 3; m_req = 1'b0; m_grow = 1'b0;
    end
    m_mode = nm;
  endtask

  always @(posedge Clk_50mhz or negedge Rst_n) begin
    if (!Rst_n) model_reset();
    else        model_tick();
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model on the falling edge
  always @(negedge Clk_50mhz) begin
    if (chk_en) begin
      check("model Step_req",   32'(Step_req),   32'(m_req));
      check("model Step_dir",   32'(Step_dir),   32'(m_dir));
      check("model Grow",       32'(Grow),       32'(m_grow));
      check("model Flash_sig",  32'(Flash_sig),  32'(((m_fc / FH) % 2) == 0));
      check("model Flash_done", 32'(Flash_done), 32'(m_fc >= FLASH_TOTAL));
    end
  end

  task automatic cyc();
    @(posedge Clk_50mhz);
    #1;
  endtask

  task automatic wait_req(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      cyc();
      n++;
      if (Step_req === 1'b1) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_req: no Step_req within 200 cycles at %0t", $time);
  endtask

  int n;
  int exp_p [4] = '{16, 12, 8, 8};
  int tog_t [6];
  int nt, done_t;
  logic last_sig;

  initial begin
    #2 Rst_n = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) cyc();
    // Reset values
    check("rst Step_req", 32'(Step_req), 0);
    check("rst Step_dir", 32'(Step_dir), 3);
    check("rst Grow", 32'(Grow), 0);
    check("rst Flash_sig", 32'(Flash_sig), 1);
    check("rst Flash_done", 32'(Flash_done), 0);
    Rst_n = 1'b1;
    cyc();

    // Play with ack tied high: first request after the period, then every period
    Game_status = 3'b010;
    Step_ack = 1'b1;
    wait_req(n);
    check("first req latency", 32'(n), 21);
    check("first req dir", 32'(Step_dir), 3);
    wait_req(n);
    check("req interval 1", 32'(n), 20);
    wait_req(n);
    check("req interval 2", 32'(n), 20);

    // Reversal blocked; simultaneous keys resolve by priority
    Key_left = 1'b1; cyc(); Key_left = 1'b0;
    wait_req(n);
    check("left ignored dir", 32'(Step_dir), 3);
    Key_up = 1'b1; Key_left = 1'b1; cyc(); Key_up = 1'b0; Key_left = 1'b0;
    wait_req(n);
    check("up wins dir", 32'(Step_dir), 0);
    Key_down = 1'b1; cyc(); Key_down = 1'b0;
    wait_req(n);
    check("down ignored dir", 32'(Step_dir), 0);

    // Ack withheld: request and direction hold, timer frozen
    cyc();
    Step_ack = 1'b0;
    wait_req(n);
    repeat (50) cyc();
    check("held req", 32'(Step_req), 1);
    check("held dir", 32'(Step_dir), 0);
    Step_ack = 1'b1;
    wait_req(n);
    check("after ack interval", 32'(n), 20);

    // Apples on ack cycles: period shrinks to the floor, growth persists
    for (int i = 0; i < 4; i++) begin
      Apple_eaten = 1'b1; cyc(); Apple_eaten = 1'b0;
      wait_req(n);
      check("apple period", 32'(n + 1), 32'(exp_p[i]));
      check("apple grow", 32'(Grow), 1);
    end
    wait_req(n);
    check("floor period", 32'(n), 8);
    check("grow drained", 32'(Grow), 0);

    // END with request pending: withdraw, then blink
    cyc();
    Step_ack = 1'b0;
    wait_req(n);
    Game_status = 3'b100;
    cyc();
    check("req dropped on END", 32'(Step_req), 0);
    nt = 0; done_t = -1; last_sig = 1'b1;
    for (int k = 1; k <= 120; k++) begin
      cyc();
      if (Flash_sig !== last_sig) begin
        if (nt < 6) tog_t[nt] = k;
        nt++;
        last_sig = Flash_sig;
      end
      if (Flash_done === 1'b1 && done_t < 0) done_t = k;
    end
    check("toggle count", 32'(nt), 6);
    for (int i = 0; i < 6; i++)
      if (i < nt) check("toggle time", 32'(tog_t[i]), 32'(10 * (i + 1)));
    check("done time", 32'(done_t), 60);
    check("hold Flash_sig", 32'(Flash_sig), 1);
    check("hold Flash_done", 32'(Flash_done), 1);

    // Leaving END mid-blink restores the display; new play restarts at base speed
    Game_status = 3'b001;
    repeat (3) cyc();
    Game_status = 3'b100;
    repeat (15) cyc();
    check("mid blink sig", 32'(Flash_sig), 0);
    Game_status = 3'b001;
    cyc();
    check("abort Flash_sig", 32'(Flash_sig), 1);
    check("abort Flash_done", 32'(Flash_done), 0);
    Game_status = 3'b010;
    Step_ack = 1'b1;
    wait_req(n);
    check("replay latency", 32'(n), 21);
    check("replay dir", 32'(Step_dir), 3);

    // Randomized play against the model
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 149) == 0) begin
        case ($urandom_range(0, 9))
          0: Game_status = 3'b001;
          1: Game_status = 3'b100;
          2: Game_status = 3'b000;
          3: Game_status = 3'b110;
          default: Game_status = 3'b010;
        endcase
      end
      Key_up      = ($urandom_range(0, 7) == 0);
      Key_down    = ($urandom_range(0, 7) == 0);
      Key_left    = ($urandom_range(0, 7) == 0);
      Key_right   = ($urandom_range(0, 7) == 0);
      Step_ack    = ($urandom_range(0, 2) == 0);
      Apple_eaten = ($urandom_range(0, 29) == 0);
      cyc();
    end
    Key_up = 1'b0; Key_down = 1'b0; Key_left = 1'b0; Key_right = 1'b0;
    Apple_eaten = 1'b0;
    repeat (2) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
